// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: issues burst reads at a sequential PC and queues PC-tagged words for decode.
// Define INST_FETCH_PERF_EN to add the perf_bursts / perf_flushed counter ports.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h8002_0000,
    parameter logic [1:0]  BURST_SIZE = 2'b01,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        mem_enable,
    output logic        mem_read_write,
    output logic [1:0]  mem_access_size,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out,
`ifdef INST_FETCH_PERF_EN
    output logic [31:0] perf_bursts,
    output logic [31:0] perf_flushed,
`endif
    input  logic        mem_busy
);

    localparam int unsigned N_WORDS = (BURST_SIZE == 2'b00) ? 1 : (1 << (32'(BURST_SIZE) + 1));
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] NW_C     = CNT_W'(N_WORDS);
    localparam logic [4:0]       NW5_C    = 5'(N_WORDS);
    localparam logic [4:0]       LAST_C   = 5'(N_WORDS - 1);
    localparam logic [31:0]      STRIDE_C = 32'(4 * N_WORDS);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_GAP   = 3'd2;
    localparam logic [2:0] S_RECV  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [4:0]  drain_q, drain_d;
    logic        skip_q, skip_d;
    logic [31:0] addr_q, addr_d;

    logic [31:0]      fifo_pc    [FIFO_DEPTH];
    logic [31:0]      fifo_instr [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic        push;
    logic        pop;
    logic        room_ok;
    logic [31:0] push_pc;
    logic        unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc[1:0];

    assign room_ok = (DEPTH_C - count_q) >= NW_C;
    assign push_pc = fetch_pc_q + {25'd0, cnt_q, 2'b00};

    assign out_valid = (count_q != '0) && !redirect;
    assign pop       = out_valid && out_ready;
    assign out_pc    = fifo_pc[rd_ptr_q];
    assign out_instr = fifo_instr[rd_ptr_q];

    assign mem_enable      = (state_q == S_REQ);
    assign mem_read_write  = 1'b1;
    assign mem_access_size = BURST_SIZE;
    assign mem_address     = addr_q;
    assign mem_data_in     = '0;

    // A redirect in REQ enters DRAIN during the bus gap cycle, so skip_q
    // suppresses counting for that one cycle before the first word arrives.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        cnt_d      = cnt_q;
        drain_d    = drain_q;
        skip_d     = skip_q;
        addr_d     = addr_q;
        push       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!redirect && !mem_busy && room_ok) begin
                    state_d = S_REQ;
                    addr_d  = fetch_pc_q;
                end
            end
            S_REQ: begin
                cnt_d = '0;
                if (redirect) begin
                    state_d = S_DRAIN;
                    drain_d = NW5_C;
                    skip_d  = 1'b1;
                end else begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (redirect) begin
                    state_d = S_DRAIN;
                    drain_d = NW5_C;
                    skip_d  = 1'b0;
                end else begin
                    state_d = S_RECV;
                end
            end
            S_RECV: begin
                if (redirect) begin
                    if (cnt_q == LAST_C) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DRAIN;
                        drain_d = LAST_C - cnt_q;
                        skip_d  = 1'b0;
                    end
                end else begin
                    push  = 1'b1;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == LAST_C) begin
                        fetch_pc_d = fetch_pc_q + STRIDE_C;
                        state_d    = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                if (skip_q) begin
                    skip_d = 1'b0;
                end else begin
                    drain_d = drain_q - 5'd1;
                    if (drain_q == 5'd1) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (redirect) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            cnt_q      <= '0;
            drain_q    <= '0;
            skip_q     <= 1'b0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            cnt_q      <= cnt_d;
            drain_q    <= drain_d;
            skip_q     <= skip_d;
            addr_q     <= addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || redirect) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr_q]    <= push_pc;
            fifo_instr[wr_ptr_q] <= mem_data_out;
        end
    end

`ifdef INST_FETCH_PERF_EN
    logic [31:0] perf_bursts_q;
    logic [31:0] perf_flushed_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_bursts_q  <= '0;
            perf_flushed_q <= '0;
        end else begin
            if (state_q == S_REQ) begin
                perf_bursts_q <= perf_bursts_q + 32'd1;
            end
            perf_flushed_q <= perf_flushed_q
                            + (redirect ? 32'(count_q) : 32'd0)
                            + ((state_q == S_DRAIN && !skip_q) ? 32'd1 : 32'd0);
        end
    end

    assign perf_bursts  = perf_bursts_q;
    assign perf_flushed = perf_flushed_q;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: a burst-memory model per instance, request/pop logs,
// and hand-computed expectations. Instance 1 runs with a wrapping RESET_PC.
module tb_inst_fetch_unit;

    localparam int unsigned NW  = 4;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst    [2];
    logic        redir  [2];
    logic        oready [2];
    logic        ovalid [2];
    logic        men    [2];
    logic        mrw    [2];
    logic        mbusy  [2];
    logic [31:0] rpc    [2];
    logic [31:0] opc    [2];
    logic [31:0] oinstr [2];
    logic [31:0] maddr  [2];
    logic [31:0] mdin   [2];
    logic [31:0] mdout  [2];
    logic [1:0]  msize  [2];
`ifdef INST_FETCH_PERF_EN
    logic [31:0] pb [2];
    logic [31:0] pf [2];
`endif

    for (genvar g = 0; g < 2; g++) begin : g_dut
        inst_fetch_unit #(
            .RESET_PC  (g == 0 ? 32'h8002_0000 : 32'hFFFF_FFF8),
            .BURST_SIZE(2'b01),
            .FIFO_DEPTH(16)
        ) dut (
            .clk            (clk),
            .reset          (rst[g]),
            .redirect       (redir[g]),
            .redirect_pc    (rpc[g]),
            .out_valid      (ovalid[g]),
            .out_ready      (oready[g]),
            .out_pc         (opc[g]),
            .out_instr      (oinstr[g]),
            .mem_enable     (men[g]),
            .mem_read_write (mrw[g]),
            .mem_access_size(msize[g]),
            .mem_address    (maddr[g]),
            .mem_data_in    (mdin[g]),
            .mem_data_out   (mdout[g]),
`ifdef INST_FETCH_PERF_EN
            .perf_bursts    (pb[g]),
            .perf_flushed   (pf[g]),
`endif
            .mem_busy       (mbusy[g])
        );
    end

    int          cyc;
    int          viol;
    int          mk      [2];
    logic        act     [2];
    logic        prev_en [2];
    logic [31:0] base    [2];
    int          req_n   [2];
    int          log_n   [2];
    logic [31:0] req_addr[2][64];
    int          req_cyc [2][64];
    logic [31:0] log_pc  [2][64];
    logic [31:0] log_in  [2][64];

    // Memory: request seen in cycle C0, word k driven in C0+2+k, busy until two cycles past the last word.
    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (men[i]) begin
                if (act[i] || prev_en[i] || msize[i] != 2'b01 || !mrw[i] || mdin[i] != 32'd0) viol++;
                if (req_n[i] < 64) begin
                    req_addr[i][req_n[i]] = maddr[i];
                    req_cyc[i][req_n[i]]  = cyc;
                end
                req_n[i]++;
                base[i] = maddr[i];
                mk[i]   = 0;
                act[i]  = 1'b1;
            end else if (act[i]) begin
                mk[i]++;
                if (mk[i] > NW + 3) act[i] = 1'b0;
            end
            prev_en[i] = men[i];
            mbusy[i]   = act[i];
            if (act[i] && mk[i] >= 2 && mk[i] <= NW + 1)
                mdout[i] = (base[i] + 32'(4 * (mk[i] - 2))) ^ KEY;
            else
                mdout[i] = 32'hDEAD_BEEF;
            if (ovalid[i] && oready[i]) begin
                if (log_n[i] < 64) begin
                    log_pc[i][log_n[i]] = opc[i];
                    log_in[i][log_n[i]] = oinstr[i];
                end
                log_n[i]++;
            end
        end
    end

    int n_chk;
    int n_pass;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic smp();
        @(negedge clk);
        #1;
    endtask

    task automatic drv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int i);
        drv();
        rst[i]   = 1'b1;
        redir[i] = 1'b0;
        repeat (2) drv();
        rst[i]   = 1'b0;
        req_n[i] = 0;
        log_n[i] = 0;
    endtask

    task automatic wait_req(input int i, input int target, input int budget, input string tag);
        int k = 0;
        while (req_n[i] < target && k < budget) begin
            smp();
            k++;
        end
        chk_eq(tag, 64'(req_n[i] >= target), 64'd1);
    endtask

    task automatic wait_pop(input int i, input int target, input int budget, input string tag);
        int k = 0;
        while (log_n[i] < target && k < budget) begin
            smp();
            k++;
        end
        chk_eq(tag, 64'(log_n[i] >= target), 64'd1);
    endtask

    logic        early;
    logic [31:0] exp_pc;
    logic [31:0] wrap_pc [4];
`ifdef INST_FETCH_PERF_EN
    logic [31:0] pf_before;
`endif

    initial begin
        n_chk = 0;
        n_pass = 0;
        cyc = 0;
        viol = 0;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1;
            redir[i] = 1'b0;
            rpc[i] = '0;
            oready[i] = 1'b1;
            mk[i] = 0;
            act[i] = 1'b0;
            prev_en[i] = 1'b0;
            base[i] = '0;
            req_n[i] = 0;
            log_n[i] = 0;
        end
        wrap_pc[0] = 32'hFFFF_FFF8;
        wrap_pc[1] = 32'hFFFF_FFFC;
        wrap_pc[2] = 32'h0000_0000;
        wrap_pc[3] = 32'h0000_0004;

        // Reset state
        smp();
        smp();
        chk_eq("rst_valid", 64'(ovalid[0]), 64'd0);
        chk_eq("rst_enable", 64'(men[0]), 64'd0);
        chk_eq("rst_address", 64'(maddr[0]), 64'd0);
        chk_eq("rst_rw", 64'(mrw[0]), 64'd1);
        chk_eq("rst_data_in", 64'(mdin[0]), 64'd0);

        // Sequential burst with decode always ready
        drv();
        rst[0] = 1'b0;
        req_n[0] = 0;
        log_n[0] = 0;
        wait_req(0, 2, 40, "t1_req_timeout");
        wait_pop(0, 4, 20, "t1_pop_timeout");
        chk_eq("t1_addr0", 64'(req_addr[0][0]), 64'h8002_0000);
        chk_eq("t1_addr1", 64'(req_addr[0][1]), 64'h8002_0010);
        chk_eq("t1_busy_gap", 64'(req_cyc[0][1] - req_cyc[0][0]), 64'd9);
        for (int k = 0; k < 4; k++) begin
            exp_pc = 32'h8002_0000 + 32'(4 * k);
            chk_eq("t1_pc", 64'(log_pc[0][k]), 64'(exp_pc));
            chk_eq("t1_instr", 64'(log_in[0][k]), 64'(exp_pc ^ KEY));
        end

        // Decode stalled: FIFO fills with 4 bursts, refills after 4 pops
        oready[0] = 1'b0;
        do_reset(0);
        repeat (60) smp();
        chk_eq("t2_req_count", 64'(req_n[0]), 64'd4);
        chk_eq("t2_addr3", 64'(req_addr[0][3]), 64'h8002_0030);
        chk_eq("t2_valid", 64'(ovalid[0]), 64'd1);
        drv();
        oready[0] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        oready[0] = 1'b0;
        wait_req(0, 5, 20, "t2_refill_timeout");
        smp();
        chk_eq("t2_pops", 64'(log_n[0]), 64'd4);
        chk_eq("t2_pc3", 64'(log_pc[0][3]), 64'h8002_000C);
        chk_eq("t2_addr4", 64'(req_addr[0][4]), 64'h8002_0040);

        // Redirect while word 1 is on the bus
        oready[0] = 1'b1;
        do_reset(0);
        wait_req(0, 1, 40, "t3_req_timeout");
        repeat (3) drv();
        redir[0] = 1'b1;
        rpc[0] = 32'h8002_1003;
        smp();
        chk_eq("t3_redir_valid", 64'(ovalid[0]), 64'd0);
        drv();
        redir[0] = 1'b0;
        early = 1'b0;
        for (int k = 0; k < 40 && req_n[0] < 2; k++) begin
            smp();
            if (ovalid[0]) early = 1'b1;
        end
        chk_eq("t3_valid_early", 64'(early), 64'd0);
        chk_eq("t3_addr1", 64'(req_addr[0][1]), 64'h8002_1000);
        wait_pop(0, 2, 20, "t3_pop_timeout");
        chk_eq("t3_pc0", 64'(log_pc[0][0]), 64'h8002_1000);
        chk_eq("t3_instr0", 64'(log_in[0][0]), 64'h25A7_1000);
        chk_eq("t3_pc1", 64'(log_pc[0][1]), 64'h8002_1004);

        // Redirect with 3 queued entries and decode ready in the same cycle
        oready[0] = 1'b0;
        do_reset(0);
        wait_req(0, 1, 40, "t4_req_timeout");
        repeat (4) drv();
        smp();
        chk_eq("t4_valid_before", 64'(ovalid[0]), 64'd1);
        drv();
        redir[0] = 1'b1;
        rpc[0] = 32'h8002_2000;
        oready[0] = 1'b1;
        smp();
        chk_eq("t4_redir_valid", 64'(ovalid[0]), 64'd0);
`ifdef INST_FETCH_PERF_EN
        pf_before = pf[0];
`endif
        drv();
        redir[0] = 1'b0;
        smp();
        chk_eq("t4_empty", 64'(ovalid[0]), 64'd0);
`ifdef INST_FETCH_PERF_EN
        chk_eq("t4_perf_flushed", 64'(pf[0] - pf_before), 64'd3);
`endif
        chk_eq("t4_no_pops", 64'(log_n[0]), 64'd0);
        wait_pop(0, 1, 30, "t4_pop_timeout");
        chk_eq("t4_pc0", 64'(log_pc[0][0]), 64'h8002_2000);

        // PC wrap past 0xFFFF_FFFC on the second instance
        drv();
        rst[1] = 1'b0;
        req_n[1] = 0;
        log_n[1] = 0;
        wait_req(1, 2, 40, "t5_req_timeout");
        wait_pop(1, 4, 20, "t5_pop_timeout");
        chk_eq("t5_addr0", 64'(req_addr[1][0]), 64'hFFFF_FFF8);
        chk_eq("t5_addr1", 64'(req_addr[1][1]), 64'h0000_0008);
        for (int k = 0; k < 4; k++) begin
            chk_eq("t5_pc", 64'(log_pc[1][k]), 64'(wrap_pc[k]));
            chk_eq("t5_instr", 64'(log_in[1][k]), 64'(wrap_pc[k] ^ KEY));
        end
        rst[1] = 1'b1;

        // Reset while word 2 is on the bus
        oready[0] = 1'b1;
        do_reset(0);
        wait_req(0, 1, 40, "t6_req_timeout");
        repeat (4) drv();
        rst[0] = 1'b1;
        drv();
        rst[0] = 1'b0;
        smp();
        chk_eq("t6_valid", 64'(ovalid[0]), 64'd0);
        chk_eq("t6_enable", 64'(men[0]), 64'd0);
        wait_req(0, 2, 30, "t6_req2_timeout");
        chk_eq("t6_addr1", 64'(req_addr[0][1]), 64'h8002_0000);
        chk_eq("t6_busy_wait", 64'(req_cyc[0][1] - req_cyc[0][0]), 64'd9);

        chk_eq("protocol", 64'(viol), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Read-side initiator for the 32-bit byte-addressed burst memory.
- Issues burst read requests at a sequential fetch PC and captures the returned words into a prefetch FIFO.
- Each word is tagged with its PC and presented to decode over a valid/ready handshake.
- Supports redirect (branch/jump): flushes the FIFO and discards in-flight words.

Parameters:
- RESET_PC, 32'h8002_0000, fetch PC after reset (bits [1:0] must be 0).
- BURST_SIZE, 2'b01, access_size driven on every request: 00=1, 01=4, 10=8, 11=16 words. N denotes this word count.
- FIFO_DEPTH, 16, prefetch entries; power of 2, must be >= N.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- redirect  in  1  one-cycle pulse: restart fetch at redirect_pc
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (forced 0)
- out_valid  out  1  FIFO head valid
- out_ready  in  1  decode accepts head
- out_pc  out  32  PC of head word
- out_instr  out  32  head instruction word
- mem_enable  out  1  memory request strobe
- mem_read_write  out  1  1=read; constant 1
- mem_access_size  out  2  burst size, = BURST_SIZE
- mem_address  out  32  burst start address
- mem_data_in  out  32  constant 0
- mem_data_out  in  32  memory read data
- mem_busy  in  1  memory busy

Behaviour:
- Memory protocol: a request is mem_enable=1 for exactly one cycle C0 with address and access_size stable. Word k (k=0..N-1, address base+4k) is on mem_data_out during cycle C0+2+k. mem_busy may stay high up to 2 cycles past the last word. A new request is legal only in a cycle with mem_busy=0.
- Reset: state=IDLE, fetch_pc=RESET_PC, FIFO empty, out_valid=0, mem_enable=0, mem_address=0, mem_read_write=1, mem_data_in=0.
- FSM states: IDLE, REQ, GAP, RECV, DRAIN.
  - IDLE: go to REQ when mem_busy=0, FIFO free slots >= N, and redirect=0.
  - REQ (1 cycle): mem_enable=1, mem_address=fetch_pc; word counter := 0; next state GAP.
  - GAP (1 cycle): next state RECV.
  - RECV: each cycle push {fetch_pc+4*cnt, mem_data_out} and increment cnt. After the push with cnt=N-1, set fetch_pc += 4N (mod 2^32) and go to IDLE.
  - DRAIN: count the remaining words of the in-flight burst without pushing; go to IDLE after the last one.
- Redirect:
  - Takes priority over all other actions in the same cycle.
  - FIFO cleared and fetch_pc := {redirect_pc[31:2],2'b00}.
  - In REQ, GAP or RECV: the request already issued still completes on the bus, so go to DRAIN with the remaining count (REQ/GAP: N words; RECV: N-1-cnt words, 0 means go to IDLE).
  - In DRAIN: restart the count as for the current burst, unchanged; fetch_pc updated.
  - In IDLE: no request is issued that cycle.
- Handshake:
  - out_valid = (FIFO count != 0) && !redirect. Pop when out_valid && out_ready.
  - out_pc/out_instr stable while out_valid=1 and not popped.
- FIFO:
  - Space is reserved at issue, so a push never finds the FIFO full.
  - Push and pop in the same cycle are allowed; count is unchanged.
  - Pop on empty is ignored.
- PC arithmetic is 32-bit unsigned and wraps past 0xFFFF_FFFC to 0.
- Reset mid-burst: returning words are ignored. The next request waits for mem_busy=0.

Optional Feature:
- Macro: INST_FETCH_PERF_EN.
- Defined: adds output ports perf_bursts[31:0] (increments on each REQ cycle) and perf_flushed[31:0] (increments by the FIFO count at redirect plus 1 per word discarded in DRAIN). Both are 0 on reset and wrap modulo 2^32.
- Undefined: these ports and counters do not exist. Behaviour is otherwise identical.

Test Plan:
- Reset, out_ready=1, memory word at addr A = A^32'hA5A5_0000 -> single enable pulse with address 0x8002_0000, size 01. Outputs out_pc 0x8002_0000..0x8002_000C with matching data, in order. Next request at 0x8002_0010, only after mem_busy=0.
- out_ready=0, FIFO_DEPTH=16, N=4 -> exactly 4 requests, then mem_enable stays 0 with count 16. After 4 pops, one new request at 0x8002_0040.
- redirect with redirect_pc=0x8002_1003 in the cycle word 1 is on the bus -> words 2-3 are not output. out_valid=0 until the new burst arrives. Next mem_address is 0x8002_1000 and the first out_pc is 0x8002_1000.
- redirect and out_ready both 1 with FIFO holding 3 entries -> out_valid=0 that cycle and FIFO empty next cycle. With INST_FETCH_PERF_EN, perf_flushed increments by 3.
- RESET_PC=0xFFFF_FFF8, N=4 -> out_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0, 0x4. Next request address 0x0000_0008.
- reset asserted during RECV word 2 -> out_valid=0 and mem_enable=0 next cycle. The first post-reset request goes to RESET_PC, only after mem_busy falls.
